pixel_memory_writer: RTL and testbench

Write-side companion to the 40x30 one-bit cell grid that the VGA read path scans. The block accepts drawing commands from game/control logic over a valid/ready handshake: single-cell write, filled rectangle, or whole-grid fill. It expands each command into a stream of one-cell-per-cycle write beats (enable, linear address, data) that drives the grid RAM's write port.

---
 rtl/pixel_memory_writer_if.sv | 30 +++
 rtl/pixel_memory_writer.sv | 206 ++++++++++++++++++++
 tb/tb_pixel_memory_writer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_memory_writer_if.sv
// Command handshake and grid write-port bundle for pixel_memory_writer.
// The slave modport is the writer; the master modport is the command source / RAM side.
interface pixel_memory_writer_if #(
  parameter int unsigned ADDR_W = 11
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_x0;
  logic [4:0]        cmd_y0;
  logic [5:0]        cmd_x1;
  logic [4:0]        cmd_y1;
  logic              cmd_value;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_value,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_value,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/pixel_memory_writer.sv
// Expands point / rectangle / fill-all commands into one-cell-per-cycle grid write beats.
// Optional range check and err pulse: define PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN.
module pixel_memory_writer #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned HEIGHT = 30,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_memory_writer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] OpPoint = 2'b00;
  localparam logic [1:0] OpRect  = 2'b01;
  localparam logic [1:0] OpFill  = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  state_e            state_q, state_d;
  logic [5:0]        xa_q, xa_d, xb_q, xb_d, x_q, x_d;
  logic [4:0]        yb_q, yb_d, y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              value_q, value_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Normalised bounds of the command currently on the bus
  logic [5:0]        cxa, cxb;
  logic [4:0]        cya, cyb;
  logic [ADDR_W-1:0] cmd_row_base;
  logic [ADDR_W-1:0] row_next;
  logic              cmd_zero;

  always_comb begin
    cxa = bus.cmd_x0;
    cxb = bus.cmd_x0;
    cya = bus.cmd_y0;
    cyb = bus.cmd_y0;
    unique case (bus.cmd_op)
      OpRect: begin
        cxa = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1;
        cxb = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0;
        cya = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1;
        cyb = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0;
      end
      OpFill: begin
        cxa = '0;
        cxb = 6'(WIDTH - 1);
        cya = '0;
        cyb = 5'(HEIGHT - 1);
      end
      OpPoint, OpRsvd: ;
      default: ;
    endcase
  end

  // The only multiply, evaluated once at acceptance; beats step row_base by WIDTH.
  assign cmd_row_base = ADDR_W'(32'(cya) * WIDTH);
  assign row_next     = row_base_q + ADDR_W'(WIDTH);

`ifdef PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN
  logic err_q, err_d;
  logic cmd_oob;

  always_comb begin
    cmd_oob = 1'b0;
    if (bus.cmd_op == OpPoint) begin
      cmd_oob = (32'(bus.cmd_x0) >= WIDTH) || (32'(bus.cmd_y0) >= HEIGHT);
    end else if (bus.cmd_op == OpRect) begin
      cmd_oob = (32'(bus.cmd_x0) >= WIDTH) || (32'(bus.cmd_y0) >= HEIGHT) ||
                (32'(bus.cmd_x1) >= WIDTH) || (32'(bus.cmd_y1) >= HEIGHT);
    end
  end

  assign cmd_zero = cmd_oob || (bus.cmd_op == OpRsvd);
  assign bus.err  = err_q;
`else
  assign cmd_zero = (bus.cmd_op == OpRsvd);
  assign bus.err  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    xa_d        = xa_q;
    xb_d        = xb_q;
    x_d         = x_q;
    yb_d        = yb_q;
    y_d         = y_q;
    row_base_d  = row_base_q;
    value_d     = value_q;
    cmd_ready_d = cmd_ready_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN
    err_d       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          xa_d        = cxa;
          xb_d        = cxb;
          x_d         = cxa;
          yb_d        = cyb;
          y_d         = cya;
          row_base_d  = cmd_row_base;
          value_d     = bus.cmd_value;
          if (cmd_zero) begin
            state_d = StDone;
            done_d  = 1'b1;
`ifdef PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            // First beat is registered on the acceptance edge
            state_d   = StRun;
            wr_en_d   = 1'b1;
            wr_addr_d = cmd_row_base + ADDR_W'(cxa);
            wr_data_d = bus.cmd_value;
          end
        end
      end
      StRun: begin
        if (x_q == xb_q && y_q == yb_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (x_q == xb_q) begin
          wr_en_d    = 1'b1;
          x_d        = xa_q;
          y_d        = y_q + 5'd1;
          row_base_d = row_next;
          wr_addr_d  = row_next + ADDR_W'(xa_q);
        end else begin
          wr_en_d   = 1'b1;
          x_d       = x_q + 6'd1;
          wr_addr_d = row_base_q + ADDR_W'(x_q + 6'd1);
        end
      end
      StDone: begin
        state_d     = StIdle;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      xa_q        <= '0;
      xb_q        <= '0;
      x_q         <= '0;
      yb_q        <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      value_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      xa_q        <= xa_d;
      xb_q        <= xb_d;
      x_q         <= x_d;
      yb_q        <= yb_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      value_q     <= value_d;
      cmd_ready_q <= cmd_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pixel_memory_writer.sv
// Scoreboard bench for pixel_memory_writer: expected beats are queued at command issue
// and popped by a negedge monitor; timing of done/ready/busy checked per command.
module tb_pixel_memory_writer;
  localparam int unsigned AW = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pixel_memory_writer_if #(.ADDR_W(AW)) bus ();

  pixel_memory_writer #(.WIDTH(40), .HEIGHT(30), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  logic [AW:0] exp_q[$];  // {data, addr}

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.wr_en === 1'b1) begin
      beats_seen++;
      if (exp_q.size() == 0) check_eq("extra_beat", 32'd1, 32'd0);
      else check_eq("beat", 32'({bus.wr_data, bus.wr_addr}), 32'(exp_q.pop_front()));
    end
  end

  // Queues the reference beats, waits for ready, then holds valid across one edge.
  task automatic start_cmd(input logic [1:0] op, input logic [5:0] x0, input logic [4:0] y0,
                           input logic [5:0] x1, input logic [4:0] y1, input logic val,
                           input bit churn, output int n, output logic e);
    int xa, xb, ya, yb, g;
    bit rej;
    rej = 1'b0;
    xa = x0; xb = x0; ya = y0; yb = y0;
    if (op == 2'b01) begin
      xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
      ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
    end else if (op == 2'b10) begin
      xa = 0; xb = 39; ya = 0; yb = 29;
    end
`ifdef PIXEL_MEMORY_WRITER_BOUNDS_CHECK_EN
    if (op == 2'b00 && (x0 >= 40 || y0 >= 30)) rej = 1'b1;
    if (op == 2'b01 && (x0 >= 40 || y0 >= 30 || x1 >= 40 || y1 >= 30)) rej = 1'b1;
    e = rej || (op == 2'b11);
`else
    e = 1'b0;
`endif
    n = 0;
    if (op != 2'b11 && !rej) begin
      for (int y = ya; y <= yb; y++) begin
        for (int x = xa; x <= xb; x++) begin
          exp_q.push_back({val, AW'(y * 40 + x)});
          n++;
        end
      end
    end
    g = 0;
    while (bus.cmd_ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x0    = x0;
    bus.cmd_y0    = y0;
    bus.cmd_x1    = x1;
    bus.cmd_y1    = y1;
    bus.cmd_value = val;
    @(posedge clk); #1;
    if (!churn) bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int n, input logic e, input bit churn);
    int done_cyc;
    bit rdy_seen;
    done_cyc = 0;
    rdy_seen = 1'b0;
    for (int c = 1; c <= 1300; c++) begin
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (bus.cmd_ready === 1'b1) rdy_seen = 1'b1;
      if (churn) begin
        bus.cmd_op    = 2'($urandom_range(0, 2));
        bus.cmd_x0    = 6'($urandom_range(0, 39));
        bus.cmd_y0    = 5'($urandom_range(0, 29));
        bus.cmd_x1    = 6'($urandom_range(0, 39));
        bus.cmd_y1    = 5'($urandom_range(0, 29));
        bus.cmd_value = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    check_eq("done_cycle", 32'(done_cyc), 32'(n + 1));
    check_eq("err", 32'(bus.err), 32'(e));
    check_eq("busy_at_done", 32'(bus.busy), 32'd1);
    check_eq("ready_in_run", 32'(rdy_seen), 32'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(bus.done), 32'd0);
    check_eq("ready_back", 32'(bus.cmd_ready), 32'd1);
    check_eq("busy_clear", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] x0, input logic [4:0] y0,
                        input logic [5:0] x1, input logic [4:0] y1, input logic val,
                        input bit churn);
    int n;
    logic e;
    start_cmd(op, x0, y0, x1, y1, val, churn, n, e);
    finish_cmd(n, e, churn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, g, base, done_in_rst;
    logic e;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_value = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_eq("rst_addr", 32'(bus.wr_addr), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("ready_pre_edge", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("ready_post_edge", 32'(bus.cmd_ready), 32'd1);

    do_cmd(2'b00, 6'd5, 5'd3, 6'd0, 5'd0, 1'b1, 1'b0);      // addr 125
    do_cmd(2'b01, 6'd21, 5'd4, 6'd20, 5'd3, 1'b1, 1'b0);    // 140,141,180,181
    do_cmd(2'b10, 6'd7, 5'd9, 6'd1, 5'd2, 1'b0, 1'b0);      // 0..1199
    do_cmd(2'b01, 6'd10, 5'd2, 6'd7, 5'd5, 1'b1, 1'b1);     // fields churn during run
    do_cmd(2'b01, 6'd0, 5'd29, 6'd39, 5'd28, 1'b1, 1'b0);   // two full rows at bottom
    do_cmd(2'b00, 6'd0, 5'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    do_cmd(2'b11, 6'd3, 5'd3, 6'd4, 5'd4, 1'b1, 1'b0);      // reserved: zero beats
    do_cmd(2'b00, 6'd40, 5'd0, 6'd0, 5'd0, 1'b1, 1'b0);     // out of range column

    // Reset in the middle of a fill
    start_cmd(2'b10, 6'd0, 5'd0, 6'd0, 5'd0, 1'b1, 1'b0, n, e);
    base = beats_seen;
    g = 0;
    while ((beats_seen - base) < 600 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("reach_600", 32'(beats_seen - base), 32'd600);
    reset = 1'b1;
    #1;
    check_eq("abort_wr_en", 32'(bus.wr_en), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_ready", 32'(bus.cmd_ready), 32'd0);
    exp_q.delete();
    done_in_rst = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.wr_en !== 1'b0) done_in_rst++;
    end
    reset = 1'b0;
    check_eq("quiet_in_reset", 32'(done_in_rst), 32'd0);
    @(posedge clk); #1;
    check_eq("no_late_done", 32'(bus.done), 32'd0);
    do_cmd(2'b00, 6'd39, 5'd29, 6'd0, 5'd0, 1'b1, 1'b0);    // addr 1199

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
